// File: rtl/matmul_calc_engine.sv
// Small signed matrix-multiply engine: C (+)= A * B, one MAC per clock.
// A and B are loaded element by element while idle; C and its sticky
// per-element overflow flags are readable combinationally at any time.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | accepts A/B writes and start requests
// CALC  | one MAC per cycle, k innermost, then j, then i
// DONE  | single-cycle completion pulse, then back to IDLE
module matmul_calc_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int DW        = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  a_wr_i,
    input  logic                  b_wr_i,
    input  logic [DW-1:0]         wr_row_i,
    input  logic [DW-1:0]         wr_col_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  start_i,
    input  logic [DW-1:0]         n_dim_i,
    input  logic [DW-1:0]         k_dim_i,
    input  logic [DW-1:0]         m_dim_i,
    input  logic                  acc_mode_i,
    input  logic [DW-1:0]         c_row_i,
    input  logic [DW-1:0]         c_col_i,
    output logic [BUS_WIDTH-1:0]  c_data_o,
    output logic                  c_ovf_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } engineState_e;

    engineState_e state;

    logic signed [DATA_WIDTH-1:0] aMem [MAX_DIM][MAX_DIM];
    logic signed [DATA_WIDTH-1:0] bMem [MAX_DIM][MAX_DIM];
    logic signed [BUS_WIDTH-1:0]  cMem [MAX_DIM][MAX_DIM];
    logic                         cOvf [MAX_DIM][MAX_DIM];

    // Loop indices and the latched last index of each dimension
    // (dimension minus one, so a full MAX_DIM range fits in DW bits).
    logic [DW-1:0] iCnt, jCnt, kCnt;
    logic [DW-1:0] nLast, kLast, mLast;
    logic          busyQ, doneQ;

    logic startAccept;
    assign startAccept = (state == IDLE) && start_i;

    // Dimension inputs beyond the array size are limited to the array size.
    function automatic logic [DW-1:0] clampDim(input logic [DW-1:0] dim);
        if (int'(dim) > MAX_DIM - 1) begin
            return DW'(MAX_DIM - 1);
        end
        return dim;
    endfunction

    // MAC datapath: product is exact in 2*DATA_WIDTH bits, then sign-extended.
    logic signed [DATA_WIDTH-1:0]   aOp, bOp;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [BUS_WIDTH-1:0]    prodExt, cCur, cSum;
    logic                           macOvf;

    assign aOp     = aMem[iCnt][kCnt];
    assign bOp     = bMem[kCnt][jCnt];
    assign prod    = (2*DATA_WIDTH)'(aOp) * (2*DATA_WIDTH)'(bOp);
    assign prodExt = BUS_WIDTH'(prod);
    assign cCur    = cMem[iCnt][jCnt];
    assign cSum    = cCur + prodExt;
    // Signed overflow: both addends share a sign that the sum does not.
    assign macOvf  = (cCur[BUS_WIDTH-1] == prodExt[BUS_WIDTH-1]) &&
                     (cSum[BUS_WIDTH-1] != cCur[BUS_WIDTH-1]);

    // Sequencer: state, loop indices, latched dimensions, busy/done flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            iCnt  <= '0;
            jCnt  <= '0;
            kCnt  <= '0;
            nLast <= '0;
            kLast <= '0;
            mLast <= '0;
            busyQ <= 1'b0;
            doneQ <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        nLast <= clampDim(n_dim_i);
                        kLast <= clampDim(k_dim_i);
                        mLast <= clampDim(m_dim_i);
                        iCnt  <= '0;
                        jCnt  <= '0;
                        kCnt  <= '0;
                        busyQ <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (kCnt == kLast) begin
                        kCnt <= '0;
                        if (jCnt == mLast) begin
                            jCnt <= '0;
                            if (iCnt == nLast) begin
                                iCnt  <= '0;
                                doneQ <= 1'b1;
                                state <= DONE;
                            end else begin
                                iCnt <= iCnt + 1'b1;
                            end
                        end else begin
                            jCnt <= jCnt + 1'b1;
                        end
                    end else begin
                        kCnt <= kCnt + 1'b1;
                    end
                end
                DONE: begin
                    busyQ <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busyQ <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Operand storage: writable only while idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int c = 0; c < MAX_DIM; c++) begin
                    aMem[r][c] <= '0;
                    bMem[r][c] <= '0;
                end
            end
        end else if (state == IDLE) begin
            if (a_wr_i) aMem[wr_row_i][wr_col_i] <= wr_data_i;
            if (b_wr_i) bMem[wr_row_i][wr_col_i] <= wr_data_i;
        end
    end

    // Result storage: cleared by a non-accumulating start, updated one MAC per CALC cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int c = 0; c < MAX_DIM; c++) begin
                    cMem[r][c] <= '0;
                    cOvf[r][c] <= 1'b0;
                end
            end
        end else if (startAccept && !acc_mode_i) begin
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int c = 0; c < MAX_DIM; c++) begin
                    cMem[r][c] <= '0;
                    cOvf[r][c] <= 1'b0;
                end
            end
        end else if (state == CALC) begin
            cMem[iCnt][jCnt] <= cSum;
            if (macOvf) cOvf[iCnt][jCnt] <= 1'b1;
        end
    end

    assign c_data_o = cMem[c_row_i][c_col_i];
    assign c_ovf_o  = cOvf[c_row_i][c_col_i];
    assign busy_o   = busyQ;
    assign done_o   = doneQ;

endmodule

// File: tb/tb_matmul_calc_engine.sv
// Bench for matmul_calc_engine, built with a 16-bit C bus so overflow
// cases are reachable with 8-bit operands.
module tb_matmul_calc_engine;

    localparam int DATA_WIDTH = 8;
    localparam int BUS_WIDTH  = 16;
    localparam int MAX_DIM    = 4;
    localparam int DW         = 2;
    localparam longint BUS_MAX = (longint'(1) <<< (BUS_WIDTH - 1)) - 1;
    localparam longint BUS_MIN = -(longint'(1) <<< (BUS_WIDTH - 1));

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b1;
    logic                  a_wr_i = 1'b0;
    logic                  b_wr_i = 1'b0;
    logic [DW-1:0]         wr_row_i = '0;
    logic [DW-1:0]         wr_col_i = '0;
    logic [DATA_WIDTH-1:0] wr_data_i = '0;
    logic                  start_i = 1'b0;
    logic [DW-1:0]         n_dim_i = '0;
    logic [DW-1:0]         k_dim_i = '0;
    logic [DW-1:0]         m_dim_i = '0;
    logic                  acc_mode_i = 1'b0;
    logic [DW-1:0]         c_row_i = '0;
    logic [DW-1:0]         c_col_i = '0;
    logic [BUS_WIDTH-1:0]  c_data_o;
    logic                  c_ovf_o;
    logic                  busy_o;
    logic                  done_o;

    matmul_calc_engine #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH),
        .MAX_DIM    (MAX_DIM)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .a_wr_i     (a_wr_i),
        .b_wr_i     (b_wr_i),
        .wr_row_i   (wr_row_i),
        .wr_col_i   (wr_col_i),
        .wr_data_i  (wr_data_i),
        .start_i    (start_i),
        .n_dim_i    (n_dim_i),
        .k_dim_i    (k_dim_i),
        .m_dim_i    (m_dim_i),
        .acc_mode_i (acc_mode_i),
        .c_row_i    (c_row_i),
        .c_col_i    (c_col_i),
        .c_data_o   (c_data_o),
        .c_ovf_o    (c_ovf_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference matrices held as plain integers.
    longint refA   [MAX_DIM][MAX_DIM];
    longint refB   [MAX_DIM][MAX_DIM];
    longint refC   [MAX_DIM][MAX_DIM];
    bit     refOvf [MAX_DIM][MAX_DIM];

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic modelReset();
        for (int r = 0; r < MAX_DIM; r++) begin
            for (int c = 0; c < MAX_DIM; c++) begin
                refA[r][c]   = 0;
                refB[r][c]   = 0;
                refC[r][c]   = 0;
                refOvf[r][c] = 1'b0;
            end
        end
    endtask

    function automatic longint wrapBus(input longint v);
        longint w;
        w = v & ((longint'(1) <<< BUS_WIDTH) - 1);
        if (w > BUS_MAX) w = w - (longint'(1) <<< BUS_WIDTH);
        return w;
    endfunction

    // C = (mode ? C : 0) + A*B over the active n x k x m range, each add wrapping.
    task automatic modelCalc(input int n, input int k, input int m, input bit mode);
        longint s;
        if (!mode) begin
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int c = 0; c < MAX_DIM; c++) begin
                    refC[r][c]   = 0;
                    refOvf[r][c] = 1'b0;
                end
            end
        end
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < m; j++) begin
                for (int kk = 0; kk < k; kk++) begin
                    s = refC[i][j] + refA[i][kk] * refB[kk][j];
                    if (s > BUS_MAX || s < BUS_MIN) refOvf[i][j] = 1'b1;
                    refC[i][j] = wrapBus(s);
                end
            end
        end
    endtask

    task automatic writeEl(input bit toA, input bit toB, input int r, input int c,
                           input int v);
        a_wr_i    = toA;
        b_wr_i    = toB;
        wr_row_i  = DW'(r);
        wr_col_i  = DW'(c);
        wr_data_i = DATA_WIDTH'(v);
        tick();
        a_wr_i = 1'b0;
        b_wr_i = 1'b0;
        if (toA) refA[r][c] = v;
        if (toB) refB[r][c] = v;
    endtask

    task automatic checkC(input string tag);
        for (int r = 0; r < MAX_DIM; r++) begin
            for (int c = 0; c < MAX_DIM; c++) begin
                c_row_i = DW'(r);
                c_col_i = DW'(c);
                #1;
                check($sformatf("%s.c[%0d][%0d]", tag, r, c), $signed(c_data_o), refC[r][c]);
                check($sformatf("%s.ovf[%0d][%0d]", tag, r, c), c_ovf_o, refOvf[r][c]);
            end
        end
        c_row_i = '0;
        c_col_i = '0;
    endtask

    task automatic loadIdentityCase();
        writeEl(1, 0, 0, 0, 1);
        writeEl(1, 0, 0, 1, 2);
        writeEl(1, 0, 1, 0, 3);
        writeEl(1, 0, 1, 1, 4);
        writeEl(0, 1, 0, 0, 1);
        writeEl(0, 1, 0, 1, 0);
        writeEl(0, 1, 1, 0, 0);
        writeEl(0, 1, 1, 1, 1);
    endtask

    // Start a run, track busy each cycle, check the done cycle and final C.
    // With guard set, a write to A[0][0] and a second start are issued mid-run.
    task automatic runCalc(input int n, input int k, input int m, input bit mode,
                           input bit guard, input string tag);
        int cyc;
        bit busyBad;
        n_dim_i    = DW'(n - 1);
        k_dim_i    = DW'(k - 1);
        m_dim_i    = DW'(m - 1);
        acc_mode_i = mode;
        start_i    = 1'b1;
        tick();
        start_i = 1'b0;
        modelCalc(n, k, m, mode);
        cyc     = 1;
        busyBad = 1'b0;
        while (done_o !== 1'b1 && cyc < 100) begin
            if (busy_o !== 1'b1) busyBad = 1'b1;
            if (guard && cyc == 2) begin
                a_wr_i    = 1'b1;
                wr_row_i  = '0;
                wr_col_i  = '0;
                wr_data_i = DATA_WIDTH'(99);
                start_i   = 1'b1;
            end
            tick();
            a_wr_i  = 1'b0;
            start_i = 1'b0;
            cyc++;
        end
        check({tag, ".done_cycle"}, cyc, n * k * m + 1);
        check({tag, ".busy_in_calc"}, busyBad, 0);
        check({tag, ".busy_at_done"}, busy_o, 1);
        tick();
        check({tag, ".done_one_cycle"}, done_o, 0);
        check({tag, ".busy_after"}, busy_o, 0);
        checkC(tag);
    endtask

    initial begin
        int extra;
        int n, k, m;
        bit mode;

        // Reset state
        modelReset();
        #2 rst_ni = 1'b0;
        #10;
        check("reset.busy", busy_o, 0);
        check("reset.done", done_o, 0);
        checkC("reset");
        rst_ni = 1'b1;
        tick();

        // Identity, accumulate, then clear again
        loadIdentityCase();
        runCalc(2, 2, 2, 1'b0, 1'b0, "ident");
        c_row_i = 2'd1; c_col_i = 2'd0; #1;
        check("ident.c10_const", $signed(c_data_o), 3);
        runCalc(2, 2, 2, 1'b1, 1'b0, "accum");
        c_row_i = 2'd1; c_col_i = 2'd1; #1;
        check("accum.c11_const", $signed(c_data_o), 8);
        runCalc(2, 2, 2, 1'b0, 1'b0, "reclear");

        // Non-square 3x1 * 1x2
        writeEl(1, 0, 0, 0, 1);
        writeEl(1, 0, 1, 0, 2);
        writeEl(1, 0, 2, 0, 3);
        writeEl(0, 1, 0, 0, 4);
        writeEl(0, 1, 0, 1, 5);
        runCalc(3, 1, 2, 1'b0, 1'b0, "nonsq");
        c_row_i = 2'd2; c_col_i = 2'd1; #1;
        check("nonsq.c21_const", $signed(c_data_o), 15);

        // Signed overflow with a 16-bit accumulator
        for (int t = 0; t < 3; t++) begin
            writeEl(1, 0, 0, t, 127);
            writeEl(0, 1, t, 0, 127);
        end
        runCalc(1, 3, 1, 1'b0, 1'b0, "ovf");
        c_row_i = '0; c_col_i = '0; #1;
        check("ovf.c00_const", $signed(c_data_o), -17149);
        check("ovf.flag_const", c_ovf_o, 1);
        writeEl(1, 1, 0, 0, -128);
        runCalc(1, 1, 1, 1'b0, 1'b0, "negsq");
        c_row_i = '0; c_col_i = '0; #1;
        check("negsq.c00_const", $signed(c_data_o), 16384);
        check("negsq.flag_const", c_ovf_o, 0);
        runCalc(1, 1, 1, 1'b1, 1'b0, "negsq_acc");

        // Busy guard: write and start during CALC have no effect
        loadIdentityCase();
        runCalc(2, 2, 2, 1'b0, 1'b1, "guard");
        extra = 0;
        for (int t = 0; t < 12; t++) begin
            if (done_o === 1'b1 || busy_o === 1'b1) extra++;
            tick();
        end
        check("guard.no_restart", extra, 0);

        // Reset in the third CALC cycle
        n_dim_i = 2'd1; k_dim_i = 2'd1; m_dim_i = 2'd1;
        acc_mode_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b0;
        #1;
        modelReset();
        check("midrst.busy", busy_o, 0);
        check("midrst.done", done_o, 0);
        checkC("midrst");
        #10 rst_ni = 1'b1;
        extra = 0;
        for (int t = 0; t < 12; t++) begin
            if (done_o === 1'b1 || busy_o === 1'b1) extra++;
            tick();
        end
        check("midrst.no_done", extra, 0);
        loadIdentityCase();
        runCalc(2, 2, 2, 1'b0, 1'b0, "rerun");

        // Random operands, dimensions and modes
        for (int it = 0; it < 10; it++) begin
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int c = 0; c < MAX_DIM; c++) begin
                    writeEl(1, 0, r, c, int'($urandom_range(255)) - 128);
                    writeEl(0, 1, r, c, int'($urandom_range(255)) - 128);
                end
            end
            n    = int'($urandom_range(MAX_DIM - 1)) + 1;
            k    = int'($urandom_range(MAX_DIM - 1)) + 1;
            m    = int'($urandom_range(MAX_DIM - 1)) + 1;
            mode = 1'($urandom_range(1));
            runCalc(n, k, m, mode, 1'b0, $sformatf("rnd%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/matmul_calc_engine.md
MATMUL_CALC_ENGINE -- requirements
Module: matmul_calc_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: signed width of every A and B element.
REQ-002 SHALL have parameter BUS_WIDTH, default 32: signed width of every C element and accumulator.
REQ-003 SHALL have parameter MAX_DIM, default BUS_WIDTH/DATA_WIDTH (4): upper bound of N, K and M; DW = clog2(MAX_DIM), minimum 1.
REQ-004 SHALL have ports, one per line:
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- a_wr_i  in  1  write A element
- b_wr_i  in  1  write B element
- wr_row_i  in  DW  row index for A/B write
- wr_col_i  in  DW  column index for A/B write
- wr_data_i  in  DATA_WIDTH  signed element value
- start_i  in  1  start-of-computation request
- n_dim_i, k_dim_i, m_dim_i  in  DW each  dimensions minus one (0 means 1)
- acc_mode_i  in  1  1 = accumulate into existing C; 0 = clear C first
- c_row_i, c_col_i  in  DW each  C read address
- c_data_o  out  BUS_WIDTH  C[c_row_i][c_col_i], combinational
- c_ovf_o  out  1  overflow flag of addressed C element, combinational
- busy_o  out  1  computation in progress
- done_o  out  1  one-cycle completion pulse

Function
REQ-005 SHALL hold A as MAX_DIM x MAX_DIM, B as MAX_DIM x MAX_DIM, C as MAX_DIM x MAX_DIM registers plus one sticky overflow bit per C element.
REQ-006 SHALL write wr_data_i to A[wr_row_i][wr_col_i] when a_wr_i=1 and to B likewise when b_wr_i=1, only in IDLE; both high writes both.
REQ-007 SHALL ignore A/B writes while busy_o=1 (contents unchanged).
REQ-008 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-009 IDLE: start_i=1 SHALL latch N=n_dim_i+1, K=k_dim_i+1, M=m_dim_i+1 and acc_mode_i, reset i=j=k=0, and go to CALC; if acc_mode_i=0, all C elements and overflow bits SHALL clear on the same edge.
REQ-010 CALC: each cycle SHALL perform exactly one MAC, C[i][j] <= C[i][j] + A[i][k]*B[k][j], signed, product 2*DATA_WIDTH sign-extended to BUS_WIDTH.
REQ-011 Loop order SHALL be k innermost, then j, then i; after i=N-1, j=M-1, k=K-1 the FSM SHALL go to DONE; CALC lasts exactly N*K*M cycles.
REQ-012 Addition SHALL wrap modulo 2^BUS_WIDTH; signed overflow of any add SHALL set that element's overflow bit, which stays set until cleared by reset or a mode-0 start.
REQ-013 DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-014 busy_o SHALL be 1 in CALC and DONE, 0 in IDLE; start_i while busy_o=1 SHALL be ignored.
REQ-015 Elements outside the latched N/K/M range SHALL not be read into the MAC and, in mode 1, SHALL keep their values.
REQ-016 c_data_o/c_ovf_o SHALL reflect register contents at all times, including mid-CALC partial sums.

Reset
REQ-017 rst_ni=0 SHALL immediately, regardless of clock, force IDLE and clear A, B, C, overflow bits, counters; busy_o=0, done_o=0.
REQ-018 Reset asserted mid-CALC SHALL abort with no done_o; first operation after release SHALL behave as from power-up.

Verification
REQ-019 Identity: A=[[1,2],[3,4]], B=I2, dims 2/2/2, mode 0, start at edge T -> busy_o high T+1..T+9, done_o high only in cycle T+9, C=[[1,2],[3,4]], all ovf=0.
REQ-020 Accumulate: repeat REQ-019 with acc_mode_i=1 -> C=[[2,4],[6,8]]; then mode 0 -> C=[[1,2],[3,4]].
REQ-021 Signed/overflow, BUS_WIDTH=16: N=M=1, K=3, A row=[127,127,127], B col=[127,127,127] -> C[0][0]=-17149 (48387 wrapped), ovf=1; A=[-128], B=[-128], K=1 -> 16384, ovf=0.
REQ-022 Non-square: N=3,K=1,M=2, A=[[1],[2],[3]], B=[[4,5]] -> C=[[4,5],[8,10],[12,15]], done_o 7 cycles after start edge.
REQ-023 Busy guard: during CALC write A[0][0]=99 and pulse start_i -> A unchanged, exactly one done_o, result unaffected.
REQ-024 Reset mid-CALC at cycle 3 of REQ-019 -> all C=0, busy_o=0, no done_o; rerun after release gives REQ-019 result.
